// File: rtl/pwm_pkg.sv
// Shared types for the PWM generator.
// dir_t is only referenced when PWM_CENTER_ALIGNED_EN is defined.
package pwm_pkg;

  // Top-level FSM state; 1 bit, exposed through busy.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Carrier slope direction for the centre-aligned carrier.
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_carrier_counter.sv
// Carrier counter for the PWM generator.
// Default build: N-bit sawtooth 0..MAX, period 2^N cycles.
// With PWM_CENTER_ALIGNED_EN: triangle 0..MAX then MAX-1..1, period 2*MAX
// cycles, with a direction flop that is reset to UP.
// 'last' is high on the final cycle of each period while running.
module pwm_carrier_counter
  import pwm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  output logic [N-1:0] count,
`ifdef PWM_CENTER_ALIGNED_EN
  output dir_t         dir,
`endif
  output logic         last
);

  localparam logic [N-1:0] MAX = '1;

`ifdef PWM_CENTER_ALIGNED_EN

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Triangle carrier: climb to MAX, descend to 1, then wrap to 0 going up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      dir   <= UP;
    end else if (!run) begin
      count <= '0;
      dir   <= UP;
    end else if (dir == UP) begin
      if (count == MAX) begin
        count <= MAX - ONE;
        dir   <= DOWN;
      end else begin
        count <= count + ONE;
      end
    end else begin
      if (count == ONE) begin
        count <= '0;
        dir   <= UP;
      end else begin
        count <= count - ONE;
      end
    end
  end

  // The period ends on the falling-slope cycle where count is 1.
  always_comb begin
    last = run && (dir == DOWN) && (count == ONE);
  end

`else

  // Sawtooth carrier: free-running increment, MAX->0 by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  // The period ends on the cycle where count is MAX.
  always_comb begin
    last = run && (count == MAX);
  end

`endif

endmodule

// File: rtl/pwm_generator.sv
// PWM generator: converts an N-bit duty word into a single-bit PWM output.
// duty is latched only at period start, so a period never glitches.
// period_done is high on the last cycle of each running period so an
// upstream generator can use it as its enable.
// Optional macro PWM_CENTER_ALIGNED_EN selects a centre-aligned carrier.
//
// Handshake: ena is a level run request, sampled only in IDLE and on the
// period_done cycle; a request seen there starts (or continues) a full
// period on the next edge, and a period once started always completes.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] duty,
  output logic         out,
  output logic         period_done,
  output logic         busy
);

  localparam logic [N-1:0] MAX = '1;

  state_t       state;
  logic [N-1:0] duty_q;
  logic [N-1:0] count;
  logic [N-1:0] count_next;
  logic         last;
  logic         run;

`ifdef PWM_CENTER_ALIGNED_EN
  dir_t         dir;
`endif

  assign run = (state == RUN);

  pwm_carrier_counter #(
    .N(N)
  ) u_carrier (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .count(count),
`ifdef PWM_CENTER_ALIGNED_EN
    .dir  (dir),
`endif
    .last (last)
  );

  // Carrier value for the next cycle, used only when the period is not ending.
  always_comb begin
    count_next = count + 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
    if (dir == DOWN) begin
      count_next = count - 1'b1;
    end else if (count == MAX) begin
      count_next = count - 1'b1;
    end
`endif
  end

  // Run FSM with the duty latch and the registered PWM output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      duty_q <= '0;
      out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ena) begin
            state  <= RUN;
            duty_q <= duty;
            out    <= (duty != '0);
          end else begin
            out    <= 1'b0;
          end
        end
        RUN: begin
          if (last) begin
            if (ena) begin
              duty_q <= duty;
              out    <= (duty != '0);
            end else begin
              state  <= IDLE;
              out    <= 1'b0;
            end
          end else begin
            out <= (count_next < duty_q);
          end
        end
        default: begin
          state <= IDLE;
          out   <= 1'b0;
        end
      endcase
    end
  end

  // Status outputs decode directly from flops, so reset clears them at once.
  always_comb begin
    period_done = last;
    busy        = run;
  end

endmodule
